// File: rtl/led_pkg.sv
// Shared definitions for the LED output stages: sample width, sample type and
// the number of ticks in one PWM frame.
package led_pkg;

    localparam int DUTY_W      = 8;
    localparam int FRAME_TICKS = 256;

    typedef logic [DUTY_W-1:0] duty_t;

endpackage

// File: rtl/pwm_led_driver_tick_gen.sv
// Prescaler that emits a one-cycle tick every PRESCALE clk cycles; shared by
// the LED stages that need a slower time base.
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic n_rst,
    output logic tick_o
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] presc_q;
    logic [CW-1:0] presc_d;

    // With PRESCALE=1 the counter sits at 0 == LAST, so tick_o is constantly high.
    always_comb begin
        presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick_o = (presc_q == LAST);

endmodule

// File: rtl/pwm_led_driver.sv
// LED PWM output stage: a one-entry shadow buffer fed over valid/ready, whose
// sample is (optionally gamma-shaped and) applied only at a 256-tick frame boundary.
module pwm_led_driver
    import led_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter bit GAMMA    = 1'b0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              pwm_out,
    output logic              frame_start,
    output logic              underrun
);

    localparam duty_t CNT_LAST = duty_t'(FRAME_TICKS - 1);

    logic tick;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .n_rst (n_rst),
        .tick_o(tick)
    );

    duty_t cnt_q,    cnt_d;
    duty_t active_q, active_d;
    duty_t shadow_q, shadow_d;
    logic  full_q,   full_d;
    logic  pwm_q,    pwm_d;
    logic  fs_q,     fs_d;
    logic  ur_q,     ur_d;

    logic                  accept;
    logic                  boundary;
    logic [2*DUTY_W-1:0]   sq;
    duty_t                 shaped;

    // Handshake: a sample transfers on any clk edge where duty_valid && duty_ready;
    // duty_ready is simply "shadow empty", so it never depends on duty_valid.
    assign accept   = duty_valid && !full_q;
    assign boundary = tick && (cnt_q == CNT_LAST);

    assign sq     = {{DUTY_W{1'b0}}, shadow_q} * {{DUTY_W{1'b0}}, shadow_q};
    assign shaped = GAMMA ? duty_t'(sq >> DUTY_W) : shadow_q;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        shadow_d = shadow_q;
        full_d   = full_q;
        pwm_d    = (active_q > cnt_q);
        fs_d     = boundary;
        ur_d     = boundary && !full_q;

        if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (accept) begin
            shadow_d = duty_in;
        end
        // A sample accepted on an empty-buffer boundary only lands in the shadow;
        // it waits for the following boundary to become active.
        if (boundary && full_q) begin
            active_d = shaped;
            full_d   = 1'b0;
        end else if (accept) begin
            full_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q    <= '0;
            active_q <= '0;
            shadow_q <= '0;
            full_q   <= 1'b0;
            pwm_q    <= 1'b0;
            fs_q     <= 1'b0;
            ur_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            full_q   <= full_d;
            pwm_q    <= pwm_d;
            fs_q     <= fs_d;
            ur_q     <= ur_d;
        end
    end

    assign duty_ready  = !full_q;
    assign pwm_out     = pwm_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

endmodule
